// File: rtl/pe_ws_bank_if.sv
// Bundles the signals of the weight-stationary PE: filter loading, MAC operands, pass control and results.
// The master side drives operands and control. The slave side is the PE.
interface pe_ws_bank_if #(
   parameter int DATA_W = 16,
   parameter int PSUM_W = 32,
   parameter int IDX_W  = 2
);
   logic [DATA_W-1:0] filt_in;
   logic              filt_wr;
   logic [IDX_W-1:0]  filt_widx;
   logic [IDX_W-1:0]  filt_sel;
   logic [DATA_W-1:0] ifmap_in;
   logic [PSUM_W-1:0] psum_in;
   logic              in_valid;
   logic [15:0]       op_len;
   logic              start;
   logic [DATA_W-1:0] ifmap_out;
   logic              ifmap_out_valid;
   logic [DATA_W-1:0] filt_out;
   logic              filt_out_wr;
   logic [PSUM_W-1:0] psum_out;
   logic              psum_valid;
   logic              busy;
   logic              complete;

   modport master (
      output filt_in, filt_wr, filt_widx, filt_sel, ifmap_in, psum_in, in_valid, op_len, start,
      input  ifmap_out, ifmap_out_valid, filt_out, filt_out_wr, psum_out, psum_valid, busy, complete
   );

   modport slave (
      input  filt_in, filt_wr, filt_widx, filt_sel, ifmap_in, psum_in, in_valid, op_len, start,
      output ifmap_out, ifmap_out_valid, filt_out, filt_out_wr, psum_out, psum_valid, busy, complete
   );
endinterface

// File: rtl/pe_ws_bank.sv
// Weight-stationary PE with a filter bank and an optionally saturating accumulate. Results arrive 2 cycles after an op and the ifmap forward arrives 1 cycle after it.
// There is no backpressure. One op is accepted per cycle while RUN is active, and ops are dropped when the PE is idle.
module pe_ws_bank #(
   parameter int DATA_W   = 16,
   parameter int PSUM_W   = 32,
   parameter int NUM_FILT = 4,
   parameter int SAT_EN   = 1
) (
   input logic         clk,
   input logic         rst_n,
   pe_ws_bank_if.slave bus
);
   localparam int IDX_W = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

   state_e                    state_q, state_d;
   logic [15:0]               cnt_q, cnt_d, len_q, len_d;
   logic signed [DATA_W-1:0]  bank_q [NUM_FILT];
   logic signed [DATA_W-1:0]  bank_d [NUM_FILT];
   logic [DATA_W-1:0]         ifmap_q, ifmap_d;
   logic                      v1_q, v1_d;
   logic signed [PSUM_W-1:0]  prod_q, prod_d;
   logic signed [PSUM_W-1:0]  psum1_q, psum1_d;
   logic [PSUM_W-1:0]         psum_out_q, psum_out_d;
   logic                      psum_valid_q, psum_valid_d;
   logic [DATA_W-1:0]         filt_out_q, filt_out_d;
   logic                      filt_out_wr_q, filt_out_wr_d;
   logic                      busy_q, busy_d;
   logic                      complete_q, complete_d;

   logic                      accept;
   logic [15:0]               cnt_next;
   logic signed [DATA_W-1:0]  coef;
   logic signed [2*DATA_W-1:0] product;
   logic signed [PSUM_W:0]    sum_wide;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      len_d         = len_q;
      bank_d        = bank_q;
      ifmap_d       = ifmap_q;
      prod_d        = prod_q;
      psum1_d       = psum1_q;
      psum_out_d    = psum_out_q;
      complete_d    = 1'b0;
      filt_out_d    = bus.filt_in;
      filt_out_wr_d = bus.filt_wr;

      accept   = (state_q == RUN) && bus.in_valid && (cnt_q != len_q);
      cnt_next = cnt_q + 16'(accept);

      // Out-of-range entries read as zero; the read sees the bank before this cycle's write
      coef    = (int'(bus.filt_sel) < NUM_FILT) ? bank_q[bus.filt_sel] : '0;
      product = coef * $signed(bus.ifmap_in);

      if (bus.filt_wr && (int'(bus.filt_widx) < NUM_FILT))
         bank_d[bus.filt_widx] = $signed(bus.filt_in);

      v1_d = accept;
      if (accept) begin
         ifmap_d = bus.ifmap_in;
         prod_d  = PSUM_W'(product);
         psum1_d = $signed(bus.psum_in);
      end

      sum_wide     = {psum1_q[PSUM_W-1], psum1_q} + {prod_q[PSUM_W-1], prod_q};
      psum_valid_d = v1_q;
      if (v1_q) begin
         if ((SAT_EN != 0) && (sum_wide[PSUM_W] != sum_wide[PSUM_W-1]))
            psum_out_d = sum_wide[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
         else
            psum_out_d = sum_wide[PSUM_W-1:0];
      end

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               len_d   = bus.op_len;
               cnt_d   = '0;
            end
         end
         RUN: begin
            cnt_d = cnt_next;
            if (cnt_next == len_q) state_d = DRAIN;
         end
         DRAIN: begin
            // Once stage 1 is empty, the last result is being produced this cycle
            if (!v1_q) begin
               state_d    = IDLE;
               complete_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         len_q         <= '0;
         for (int i = 0; i < NUM_FILT; i++) bank_q[i] <= '0;
         ifmap_q       <= '0;
         v1_q          <= 1'b0;
         prod_q        <= '0;
         psum1_q       <= '0;
         psum_out_q    <= '0;
         psum_valid_q  <= 1'b0;
         filt_out_q    <= '0;
         filt_out_wr_q <= 1'b0;
         busy_q        <= 1'b0;
         complete_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         len_q         <= len_d;
         bank_q        <= bank_d;
         ifmap_q       <= ifmap_d;
         v1_q          <= v1_d;
         prod_q        <= prod_d;
         psum1_q       <= psum1_d;
         psum_out_q    <= psum_out_d;
         psum_valid_q  <= psum_valid_d;
         filt_out_q    <= filt_out_d;
         filt_out_wr_q <= filt_out_wr_d;
         busy_q        <= busy_d;
         complete_q    <= complete_d;
      end
   end

   assign bus.ifmap_out       = ifmap_q;
   assign bus.ifmap_out_valid = v1_q;
   assign bus.filt_out        = filt_out_q;
   assign bus.filt_out_wr     = filt_out_wr_q;
   assign bus.psum_out        = psum_out_q;
   assign bus.psum_valid      = psum_valid_q;
   assign bus.busy            = busy_q;
   assign bus.complete        = complete_q;
endmodule

// File: doc/pe_ws_bank.md
PE_WS_BANK -- requirements
Module: pe_ws_bank

Interface
REQ-001 Parameter DATA_W, default 16: signed width of ifmap and filter operands.
REQ-002 Parameter PSUM_W, default 32: signed width of partial-sum in/out, >= 2*DATA_W.
REQ-003 Parameter NUM_FILT, default 4: depth of stationary filter bank; IDX_W = max(1, clog2(NUM_FILT)).
REQ-004 Parameter SAT_EN, default 1: 1 = saturate accumulate, 0 = two's-complement wrap.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 filt_in  in  DATA_W  filter word to write into bank.
REQ-008 filt_wr  in  1  write filt_in into bank[filt_widx] this cycle.
REQ-009 filt_widx  in  IDX_W  bank write index.
REQ-010 filt_sel  in  IDX_W  bank entry used by the op issued this cycle.
REQ-011 ifmap_in  in  DATA_W  input activation.
REQ-012 psum_in  in  PSUM_W  upstream partial sum.
REQ-013 in_valid  in  1  ifmap_in/psum_in/filt_sel valid; issues one MAC op.
REQ-014 op_len  in  16  ops per pass; sampled on start.
REQ-015 start  in  1  begin pass; clears op counter.
REQ-016 ifmap_out  out  DATA_W  registered ifmap forward to neighbour PE.
REQ-017 ifmap_out_valid  out  1  qualifies ifmap_out.
REQ-018 filt_out  out  DATA_W  registered copy of filt_in for chain loading.
REQ-019 filt_out_wr  out  1  registered copy of filt_wr.
REQ-020 psum_out  out  PSUM_W  accumulated partial sum.
REQ-021 psum_valid  out  1  qualifies psum_out.
REQ-022 busy  out  1  high in RUN state.
REQ-023 complete  out  1  one-cycle pulse at end of pass.

Function
REQ-024 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN when accepted-op count reaches op_len; DRAIN->IDLE after last op's psum_valid; start in RUN/DRAIN ignored.
REQ-025 In IDLE, in_valid is ignored: no op issued, ifmap_out_valid/psum_valid stay 0.
REQ-026 op_len = 0 on start: RUN->DRAIN next cycle, complete pulses one cycle after, no ops.
REQ-027 Stage 1 (cycle N+1 after accepted op at N): register ifmap_in, product = bank[filt_sel]*ifmap_in (signed, 2*DATA_W, sign-extended to PSUM_W), psum_in; ifmap_out/ifmap_out_valid update here (latency 1).
REQ-028 Stage 2 (cycle N+2): psum_out = psum + product; psum_valid = 1 (latency 2); one result per cycle, no bubbles.
REQ-029 SAT_EN=1: overflow clamps to max/min signed PSUM_W; SAT_EN=0: wraps modulo 2^PSUM_W.
REQ-030 Outputs hold last value when valid low; valid flags are 0 in any cycle with no op in that stage.
REQ-031 filt_wr legal in any state; same-cycle filt_wr and op with filt_widx == filt_sel: op uses old entry, new value visible next cycle.
REQ-032 filt_out/filt_out_wr register filt_in/filt_wr with latency 1 regardless of state.
REQ-033 filt_sel/filt_widx >= NUM_FILT (non-power-of-2 depth): write dropped, read returns 0.
REQ-034 complete asserts the cycle DRAIN->IDLE; start in that same cycle is accepted (IDLE->RUN next cycle).

Reset
REQ-035 rst_n low asynchronously clears: FSM to IDLE, op counter, all bank entries, all pipeline registers, all outputs to 0.
REQ-036 Reset mid-pass discards in-flight ops; no psum_valid or complete after release until a new start.
REQ-037 Deassertion is synchronised externally; first edge after release may accept start.

Verification
REQ-038 Bank write 3->idx0, 5->idx1; start op_len=2; ops (ifmap 2, psum 10, sel0),(ifmap -4, psum 1, sel1) -> psum_out 16 then -19 on consecutive cycles, complete after second.
REQ-039 SAT_EN=1, PSUM_W=32: psum_in 0x7FFF_FFF0, filt 0x7FFF, ifmap 0x7FFF -> psum_out 0x7FFF_FFFF; SAT_EN=0 -> wrapped sum.
REQ-040 Same-cycle filt_wr 9->idx0 and op sel0 (old 3, ifmap 1, psum 0) -> psum_out 3; next op -> 9.
REQ-041 in_valid toggled in IDLE -> no psum_valid, no ifmap_out_valid.
REQ-042 rst_n low after 1 of 4 ops -> outputs 0 asynchronously; after release no complete until new start.
REQ-043 op_len=0 -> busy one cycle, complete pulse, psum_valid never asserted.
